// File: rtl/flash_game_reader_pkg.sv
// Shared definitions for the SPI NOR game-image reader.
// Build option: FLASH_FAST_READ_EN selects the FAST READ (0x0B) command with
// eight dummy clocks; otherwise plain READ (0x03) is issued.
package flash_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] FLASH_OP_READ      = 8'h03;
    localparam logic [7:0] FLASH_OP_FAST_READ = 8'h0B;

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] FLASH_OPCODE = FLASH_OP_FAST_READ;
`else
    localparam logic [7:0] FLASH_OPCODE = FLASH_OP_READ;
`endif

    // State encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_CSHOLD = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CMD    = ST_CMD,
        ADDR   = ST_ADDR,
        DUMMY  = ST_DUMMY,
        DATA   = ST_DATA,
        CSHOLD = ST_CSHOLD,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/flash_game_reader_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV clk cycles while run is high.
// rise_en / fall_en mark the clk edge on which sck goes high / low, so the
// caller can sample MISO and shift MOSI on exactly those edges.
// Dropping run forces sck low at once and clears the divider.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic sck,
    output logic rise_en,
    output logic fall_en
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       sck_q;
    logic       wrap;

    assign wrap    = run && (cnt == DIV_LAST);
    assign rise_en = wrap && !sck_q;
    assign fall_en = wrap &&  sck_q;
    // Gating with run keeps sck low on the same cycle chip select rises.
    assign sck     = sck_q & run;

    // Half-period counter and sck toggle flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            sck_q <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            sck_q <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt   <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/flash_game_reader.sv
// Streams an iNES image out of SPI NOR flash (mode 0, MSB first) into the
// game loader. Each received byte is presented on out_data with a one-cycle
// out_strobe. Streaming ends on the loader's stop level, on the MAX_BYTES
// cap, or on reset.
// Build option: FLASH_FAST_READ_EN (FAST READ opcode plus a DUMMY phase).
// CLK_DIV must be 2..255 in the default build, 1..255 with the option.
module flash_game_reader
    import flash_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = 24'h100000,
    parameter int                CLK_DIV    = 2,
    parameter logic [21:0]       MAX_BYTES  = 22'h200000,
    parameter int                CS_HOLD    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [7:0]  out_data,
    output logic        out_strobe,
    output logic        busy,
    output logic        done,
    output logic [21:0] byte_count
);

    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

    state_t      state;
    logic [30:0] tx_sr;     // opcode/address bits still to be sent
    logic [6:0]  rx_sr;     // first seven bits of the byte being received
    logic [4:0]  bit_cnt;   // SCK falls in CMD/ADDR/DUMMY, rises mod 8 in DATA
    logic [7:0]  hold_cnt;
    logic        sck_run;
    logic        sck_rise;
    logic        sck_fall;
    logic        in_header;
    logic        at_boundary;
    logic        abort;

    // The divider runs exactly while chip select is asserted.
    assign sck_run = ~spi_cs_n;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (sck_run),
        .sck     (spi_sck),
        .rise_en (sck_rise),
        .fall_en (sck_fall)
    );

    // Leaving the transfer early: stop during the header abandons it at once;
    // in DATA we only leave on the SCK fall that ends a byte, so sck returns
    // low and CS rises together.
    always_comb begin
        in_header   = (state == CMD) || (state == ADDR) || (state == DUMMY);
        at_boundary = (state == DATA) && sck_fall && (bit_cnt[2:0] == 3'd0);
        abort       = (in_header && stop) ||
                      (at_boundary && (stop || byte_count == MAX_BYTES));
    end

    // Main FSM with registered SPI and loader-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            spi_cs_n   <= 1'b1;
            spi_mosi   <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            out_data   <= '0;
            out_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
        end else begin
            out_strobe <= 1'b0;
            if (abort) begin
                state    <= CSHOLD;
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                bit_cnt  <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state      <= CMD;
                            spi_cs_n   <= 1'b0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            byte_count <= '0;
                            bit_cnt    <= '0;
                            // First opcode bit goes out with CS; the rest
                            // shift on each SCK fall.
                            spi_mosi   <= FLASH_OPCODE[7];
                            tx_sr      <= {FLASH_OPCODE[6:0], START_ADDR};
                        end
                    end
                    CMD: begin
                        if (sck_fall) begin
                            spi_mosi <= tx_sr[30];
                            tx_sr    <= {tx_sr[29:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                state   <= ADDR;
                                bit_cnt <= '0;
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_fall) begin
                            spi_mosi <= tx_sr[30];
                            tx_sr    <= {tx_sr[29:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                spi_mosi <= 1'b0;
                                bit_cnt  <= '0;
`ifdef FLASH_FAST_READ_EN
                                state    <= DUMMY;
`else
                                state    <= DATA;
`endif
                            end
                        end
                    end
                    DUMMY: begin
                        spi_mosi <= 1'b0;
                        if (sck_fall) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                    end
                    DATA: begin
                        spi_mosi <= 1'b0;
                        if (sck_rise) begin
                            rx_sr   <= {rx_sr[5:0], spi_miso};
                            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                            // A byte completing while stop is high is dropped.
                            if (bit_cnt[2:0] == 3'd7 && !stop &&
                                byte_count != MAX_BYTES) begin
                                out_data   <= {rx_sr, spi_miso};
                                out_strobe <= 1'b1;
                                byte_count <= byte_count + 22'd1;
                            end
                        end
                    end
                    CSHOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        spi_cs_n <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_game_reader.sv
// Scoreboard bench for flash_game_reader with a behavioural SPI flash.
// Build option FLASH_FAST_READ_EN switches the expected header and CLK_DIV.
module tb_flash_game_reader;

`ifdef FLASH_FAST_READ_EN
    localparam int         CD       = 1;
    localparam int         HDR_BITS = 40;
    localparam logic [7:0] EXP_OP   = 8'h0B;
`else
    localparam int         CD       = 2;
    localparam int         HDR_BITS = 32;
    localparam logic [7:0] EXP_OP   = 8'h03;
`endif
    localparam int          HOLD  = 4;
    localparam logic [21:0] MAXB  = 22'd32;
    localparam logic [23:0] START = 24'h100000;
    localparam int          BYTE_BUDGET = 16 * CD + 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n, spi_sck, spi_mosi;
    logic [7:0]  out_data;
    logic        out_strobe, busy, done;
    logic [21:0] byte_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    bit chk_bound = 1'b0;

    flash_game_reader #(
        .START_ADDR (START),
        .CLK_DIV    (CD),
        .MAX_BYTES  (MAXB),
        .CS_HOLD    (HOLD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // Flash contents relative to START: iNES header, then a ramp.
    function automatic logic [7:0] rom_byte(input int i);
        case (i)
            0: rom_byte = 8'h4E;
            1: rom_byte = 8'h45;
            2: rom_byte = 8'h53;
            3: rom_byte = 8'h1A;
            4: rom_byte = 8'h01;
            5: rom_byte = 8'h01;
            6: rom_byte = 8'h00;
            7: rom_byte = 8'h00;
            default: rom_byte = (i < 64) ? 8'(i + 32) : 8'hFF;
        endcase
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Flash model and output monitor, both sampled on the falling clk edge.
    int         cyc = 0;
    int         fbits = 0;
    logic [31:0] fhdr = '0;
    bit         dummy_bad = 1'b0;
    int         d;
    logic [7:0] b;
    bit         p_sck = 1'b0, p_cs_n = 1'b1, p_strobe = 1'b0, p_done = 1'b0;
    bit         have_last = 1'b0;
    int         last_strobe = 0, rises = 0, last_sck_hi = 0, cs_rise = 0;

    always @(negedge clk) begin
        cyc++;
        // flash side
        if (spi_cs_n) begin
            fbits     = 0;
            dummy_bad = 1'b0;
        end else begin
            if (spi_sck && !p_sck) begin
                if (fbits < 32) fhdr = {fhdr[30:0], spi_mosi};
                else if (fbits < HDR_BITS) dummy_bad = dummy_bad | spi_mosi;
                fbits++;
                if (fbits == 32) begin
                    check("hdr_opcode", fhdr[31:24], EXP_OP);
                    check("hdr_addr", fhdr[23:0], START);
                end
`ifdef FLASH_FAST_READ_EN
                if (fbits == HDR_BITS) check("dummy_mosi_zero", dummy_bad, 0);
`endif
            end
            if (!spi_sck && p_sck && fbits >= HDR_BITS) begin
                d = fbits - HDR_BITS;
                b = rom_byte(int'(fhdr[23:0] - START) + d / 8);
                spi_miso = b[7 - d % 8];
            end
        end
        // monitor side
        if (spi_sck) last_sck_hi = cyc;
        if (!spi_cs_n && p_cs_n) begin
            have_last = 1'b0;
            rises     = 0;
        end
        if (spi_sck && !p_sck) rises++;
        if (out_strobe) begin
            check("strobe_width", p_strobe, 0);
            if (have_last) begin
                n_cmp++;
                if (cyc - last_strobe < 16 * CD) begin
                    n_bad++;
                    $display("FAIL strobe_gap: got %0d cycles, need >= %0d", cyc - last_strobe, 16 * CD);
                end
            end
            have_last   = 1'b1;
            last_strobe = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_strobe: got data 0x%0h, no byte expected", out_data);
            end else begin
                check("strobe_data", out_data, exp_q.pop_front());
            end
        end
        if (spi_cs_n && !p_cs_n) begin
            cs_rise = cyc;
            if (chk_bound) begin
                check("cs_within_1clk_of_boundary", (cyc - last_sck_hi) <= 1, 1);
                check("sck_rises_whole_bytes", rises % 8, 0);
            end
        end
        if (done && !p_done) check("done_after_cs_hold", cyc - cs_rise, HOLD);
        p_sck    = spi_sck;
        p_cs_n   = spi_cs_n;
        p_strobe = out_strobe;
        p_done   = done;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input string name);
        int k = 0;
        int t = 0;
        while (k < n && t < (n + 3) * BYTE_BUDGET + 100) begin
            @(negedge clk);
            t++;
            if (out_strobe) k++;
        end
        check(name, k, n);
    endtask

    task automatic wait_done(input int budget, input string name);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, done, 1);
    endtask

    task automatic wait_rises(input int n, input string name);
        int k = 0;
        int t = 0;
        bit ps = spi_sck;
        while (k < n && t < 4 * n * CD + 50) begin
            @(negedge clk);
            t++;
            if (spi_sck && !ps) k++;
            ps = spi_sck;
        end
        check(name, k, n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_out_data", out_data, 0);
        check("rst_strobe", out_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_byte_count", byte_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic load: 24 bytes then stop; a start mid-stream is ignored
        chk_bound = 1'b1;
        for (int i = 0; i < 24; i++) exp_q.push_back(rom_byte(i));
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_cs_low", spi_cs_n, 0);
        wait_strobes(10, "t1_first10");
        pulse_start();
        wait_strobes(14, "t1_rest14");
        stop = 1'b1;
        wait_done(BYTE_BUDGET + 50, "t1_done");
        check("t1_byte_count", byte_count, 24);
        check("t1_busy_low", busy, 0);
        check("t1_queue_empty", exp_q.size(), 0);
        stop = 1'b0;

        // stop three SCK periods into byte 20: that byte is dropped
        for (int i = 0; i < 20; i++) exp_q.push_back(rom_byte(i));
        pulse_start();
        check("t2_done_cleared", done, 0);
        wait_strobes(20, "t2_20bytes");
        repeat (6 * CD) @(negedge clk);
        stop = 1'b1;
        wait_done(2 * BYTE_BUDGET + 50, "t2_done");
        repeat (20 * CD) @(negedge clk);
        check("t2_byte_count", byte_count, 20);
        check("t2_queue_empty", exp_q.size(), 0);
        stop = 1'b0;

        // cap: no stop, MAX_BYTES ends the stream
        for (int i = 0; i < 32; i++) exp_q.push_back(rom_byte(i));
        pulse_start();
        wait_done(36 * BYTE_BUDGET + 200, "t3_done");
        repeat (20 * CD) @(negedge clk);
        check("t3_byte_count", byte_count, 32);
        check("t3_done_level", done, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // reset during ADDR, then a fresh start re-sends the whole command
        chk_bound = 1'b0;
        pulse_start();
        wait_rises(12, "t4_reach_addr");
        reset_n = 1'b0;
        #1;
        check("t4_cs_high_async", spi_cs_n, 1);
        check("t4_busy_low_async", busy, 0);
        check("t4_sck_low_async", spi_sck, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t4_byte_count_cleared", byte_count, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(rom_byte(i));
        pulse_start();
        chk_bound = 1'b1;
        wait_strobes(4, "t4_4bytes");
        stop = 1'b1;
        wait_done(BYTE_BUDGET + 50, "t4_done");
        check("t4_byte_count", byte_count, 4);
        check("t4_queue_empty", exp_q.size(), 0);
        stop = 1'b0;

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // absolute time bound in case a wait loop is defeated
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flash_game_reader.md
Name: flash_game_reader

Overview:
- Upstream feeder for the iNES game loader.
- After `start`, it streams a ROM image out of the board's SPI NOR flash using a READ command (mode 0, MSB first).
- Each received byte appears on `out_data` with a one-cycle `out_strobe`. These connect directly to the loader's `indata`/`indata_clk`.
- It stops when the loader reports done, when `MAX_BYTES` have been delivered, or on reset.

Parameters:
- START_ADDR, 24'h100000, flash byte address of the iNES header's first byte.
- CLK_DIV, 2, clk cycles per SCK half-period. Legal range 1..255.
- MAX_BYTES, 22'h200000, hard cap on bytes delivered. Guards against a blank or corrupt flash.
- CS_HOLD, 4, clk cycles that `spi_cs_n` stays high after a transfer, before `done` asserts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse that begins a load. Ignored unless in IDLE or DONE.
- stop  in  1  level from the loader's `done`. Ends streaming.
- spi_cs_n  out  1  flash chip select, active low
- spi_sck  out  1  flash clock, idle low
- spi_mosi  out  1  flash data in
- spi_miso  in  1  flash data out
- out_data  out  8  last received byte, held until the next byte
- out_strobe  out  1  one-cycle pulse when `out_data` is new
- busy  out  1  high from `start` acceptance until DONE
- done  out  1  high in DONE. Cleared by the next accepted `start`.
- byte_count  out  22  bytes strobed since the last `start`

Behaviour:
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `out_data`=0, `out_strobe`=0, `busy`=0, `done`=0, `byte_count`=0. State is IDLE.
- Reset mid-transfer: deasserts CS immediately (asynchronously). No further strobes.
- FSM states: IDLE, CMD, ADDR, DATA, CSHOLD, DONE.
- IDLE/DONE -> CMD on `start`:
  - drive `spi_cs_n`=0, `busy`=1, `done`=0
  - clear `byte_count`
  - load shift register with opcode 8'h03
- SCK generation: a divider counter toggles `spi_sck` every CLK_DIV clk cycles, only while in CMD/ADDR/DATA.
- Mode 0 timing:
  - MOSI updates on the clk edge where SCK falls; the first bit is driven on entry to CMD.
  - MISO is sampled on the clk edge where SCK rises.
- CMD: 8 SCK periods, then -> ADDR.
- ADDR: 24 SCK periods shifting START_ADDR MSB first, then -> DATA.
- DATA:
  - MOSI is held at 0.
  - After the 8th rising edge of each byte, the shifted byte goes to `out_data`, `out_strobe` pulses for exactly one cycle, and `byte_count` increments.
  - Minimum strobe spacing is 16*CLK_DIV clk cycles (≥2). This spacing is required by the loader, which drops a strobe during its PRG->CHR switch cycle.
- DATA -> CSHOLD at the next byte boundary when `stop`=1 or `byte_count`==MAX_BYTES:
  - a byte in flight when `stop` rises is discarded, never strobed
  - `spi_sck` returns to 0 and `spi_cs_n`=1 on the same cycle
- `stop`=1 sampled in CMD/ADDR: finish nothing. Go directly to CSHOLD.
- CSHOLD: count CS_HOLD cycles, then -> DONE with `busy`=0, `done`=1.
- `start` during CMD/ADDR/DATA/CSHOLD is ignored.
- `byte_count` saturates at MAX_BYTES. No wrap-around.
- Flash addressing wraps at 16 MB inside the flash itself; the block takes no action.

Optional Feature:
- FLASH_FAST_READ_EN defined:
  - opcode becomes 8'h0B
  - a DUMMY state (8 SCK periods, MOSI=0) is inserted between ADDR and DATA
  - CLK_DIV may legally be 1
- Undefined: opcode 8'h03, no DUMMY state, CLK_DIV must be ≥2.

Decomposition:
- Shared package `flash_pkg`:
  - opcode constants FLASH_OP_READ=8'h03 and FLASH_OP_FAST_READ=8'h0B
  - state encoding localparams
  - address width 24
- One sub-module, `spi_sck_gen`: the divider. Its outputs:
  - `sck`
  - one-cycle `rise_en` and `fall_en` strobes
  - an `run` input; when low it forces `sck` low and clears the counter.
- The top holds the FSM, shift registers and counters.

Test Plan:
- Basic load: flash model preloaded with "NES\x1A",1,1,… at 0x100000, CLK_DIV=2, `start`, then `stop` after 16+16384+8192 bytes.
  - MOSI shows 0x03,0x10,0x00,0x00.
  - 24592 strobes with matching data.
  - `done`=1 exactly CS_HOLD cycles after CS rises.
- Strobe spacing: CLK_DIV=1.
  - Every adjacent `out_strobe` pair is ≥16 clk apart.
  - Each `out_strobe` is exactly 1 cycle wide.
- Stop mid-byte: `stop` raised 3 SCK periods into byte 20.
  - `byte_count`=20.
  - No 21st strobe.
  - CS high within 1 clk of the byte boundary.
- Cap: MAX_BYTES=22'd32, `stop` never asserted.
  - Exactly 32 strobes.
  - `byte_count`=32, `done`=1.
- Reset mid-ADDR: `reset_n` low for 1 cycle.
  - `spi_cs_n`=1 and `busy`=0 immediately.
  - A fresh `start` re-issues the full command.
- FLASH_FAST_READ_EN build:
  - MOSI shows 0x0B, address, then 8 dummy clocks.
  - First strobed byte = 0x4E.
